serial_shifter: RTL and testbench

- Multi-cycle bitwise shift unit for the RV32 datapath.
- Handles SLL/SRL/SRA (and SLLI/SRLI/SRAI) by moving one bit position per clock, so no barrel shifter is needed.
- Sits beside the combinational logic units in the ALU path.
- Uses a valid/ready handshake on input and output so the core can stall on it.

---
 rtl/shifter_pkg.sv | 17 +
 rtl/shift_step.sv | 23 ++
 rtl/serial_shifter.sv | 80 ++++++++
 tb/tb_serial_shifter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared encodings for the serial shift unit: operation codes and FSM states.
package shifter_pkg;

   typedef enum logic [1:0] {
      OP_SLL  = 2'b00,
      OP_SRL  = 2'b01,
      OP_PASS = 2'b10,
      OP_SRA  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_e;

endpackage

// File: rtl/shift_step.sv
// One-position shift with operation-dependent fill bit; PASS returns the value unchanged.
module shift_step
   import shifter_pkg::*;
#(
   parameter int unsigned n = 32
) (
   input  logic [n-1:0] value,
   input  op_e          op,
   output logic [n-1:0] shifted
);

   always_comb begin
      shifted = value;
      unique case (op)
         OP_SLL:  shifted = {value[n-2:0], 1'b0};
         OP_SRL:  shifted = {1'b0, value[n-1:1]};
         OP_SRA:  shifted = {value[n-1], value[n-1:1]};
         OP_PASS: shifted = value;
         default: shifted = value;
      endcase
   end

endmodule

// File: rtl/serial_shifter.sv
// Multi-cycle SLL/SRL/SRA unit: one bit position per clock behind valid/ready handshakes.
module serial_shifter
   import shifter_pkg::*;
#(
   parameter  int unsigned n  = 32,
   localparam int unsigned SW = $clog2(n)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [n-1:0]  a,
   input  logic [SW-1:0] shamt,
   input  logic [1:0]    op,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [n-1:0]  y
);

   state_e        state;
   op_e           op_q;
   logic [SW-1:0] count;
   logic [n-1:0]  result;
   logic [n-1:0]  stepped;

   shift_step #(.n(n)) u_step (
      .value   (result),
      .op      (op_q),
      .shifted (stepped)
   );

   assign in_ready = (state == IDLE);
   assign y        = result;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         op_q      <= OP_SLL;
         count     <= '0;
         result    <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  result <= a;
                  count  <= shamt;
                  op_q   <= op_e'(op);
                  // Zero-distance shifts and PASS skip SHIFT entirely.
                  if (shamt == '0 || op_e'(op) == OP_PASS) begin
                     state     <= DONE;
                     out_valid <= 1'b1;
                  end else begin
                     state <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               result <= stepped;
               count  <= count - SW'(1);
               if (count == SW'(1)) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_shifter.sv
// Bench for serial_shifter: behavioural reference checked every cycle plus directed literal checks.
module tb_serial_shifter;

   localparam int unsigned N = 32;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [N-1:0] a;
   logic [4:0]  shamt;
   logic [1:0]  op;
   logic        out_valid;
   logic        out_ready;
   logic [N-1:0] y;

   int errors = 0;
   int checks = 0;

   serial_shifter #(.n(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .shamt     (shamt),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] v, input logic [4:0] s);
      case (o)
         2'b00:   return v << s;
         2'b01:   return v >> s;
         2'b11:   return $unsigned($signed(v) >>> s);
         default: return v;
      endcase
   endfunction

   // Reference: a request is owed s+1 edges (accept edge included) before its result shows.
   bit          m_on = 1'b0;
   bit          m_busy = 1'b0;
   bit          m_valid = 1'b0;
   bit          m_y_zero = 1'b0;
   int          m_wait = 0;
   logic [31:0] m_res = '0;

   always @(posedge clk) begin
      if (rst) begin
         m_on = 1'b1; m_busy = 1'b0; m_valid = 1'b0; m_wait = 0; m_y_zero = 1'b1;
      end else if (m_on) begin
         if (!m_busy) begin
            if (in_valid) begin
               m_busy   = 1'b1;
               m_y_zero = 1'b0;
               m_res    = ref_shift(op, a, shamt);
               m_wait   = (op == 2'b10) ? 0 : int'(shamt);
               m_valid  = (m_wait == 0);
            end
         end else if (!m_valid) begin
            m_wait--;
            m_valid = (m_wait == 0);
         end else if (out_ready) begin
            m_busy = 1'b0; m_valid = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (m_on) begin
         check("in_ready", 32'(in_ready), 32'(!m_busy));
         check("out_valid", 32'(out_valid), 32'(m_valid));
         if (m_valid) check("y", y, m_res);
         if (m_y_zero) check("y_after_reset", y, '0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Present a request and return once it has been accepted.
   task automatic issue(input logic [1:0] o, input logic [31:0] v, input logic [4:0] s);
      bit acc;
      op = o; a = v; shamt = s; in_valid = 1'b1;
      acc = 1'b0;
      for (int i = 0; i < 200 && !acc; i++) begin
         acc = in_ready;
         tick();
      end
      if (!acc) check("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
   endtask

   // Count edges from the accept edge (as 1) until out_valid, then check result and latency.
   task automatic await(input string name, input logic [31:0] exp_y, input int exp_lat);
      int lat;
      lat = 1;
      while (!out_valid && lat < 200) begin
         tick();
         lat++;
      end
      check({name, "_lat"}, 32'(lat), 32'(exp_lat));
      check({name, "_y"}, y, exp_y);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; a = '0; shamt = '0; op = 2'b00; out_ready = 1'b1;
      tick(); tick();
      rst = 1'b0;
      check("reset_in_ready", 32'(in_ready), 32'd1);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_y", y, 32'h0);

      issue(2'b00, 32'h0000_0001, 5'd31);
      await("sll31", 32'h8000_0000, 32);
      tick();
      issue(2'b11, 32'h8000_0000, 5'd4);
      await("sra4", 32'hF800_0000, 5);
      tick();
      issue(2'b01, 32'h8000_0000, 5'd4);
      await("srl4", 32'h0800_0000, 5);
      tick();
      issue(2'b00, 32'hDEAD_BEEF, 5'd0);
      await("sll0", 32'hDEAD_BEEF, 1);
      tick();
      issue(2'b10, 32'hDEAD_BEEF, 5'd7);
      await("pass7", 32'hDEAD_BEEF, 1);
      tick();

      // Backpressure with a competing request held on the input.
      out_ready = 1'b0;
      issue(2'b00, 32'h0000_00FF, 5'd8);
      await("bp", 32'h0000_FF00, 9);
      op = 2'b00; a = 32'h1; shamt = 5'd1; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("bp_hold_y", y, 32'h0000_FF00);
         check("bp_hold_valid", 32'(out_valid), 32'd1);
         check("bp_hold_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      tick();
      check("bp_idle_bubble", 32'(in_ready), 32'd1);
      check("bp_idle_out_valid", 32'(out_valid), 32'd0);
      issue(2'b00, 32'h1, 5'd1);
      await("bp_second", 32'h0000_0002, 2);
      tick();

      // Reset mid-shift; a request presented alongside reset must be dropped.
      issue(2'b00, 32'h0000_0001, 5'd20);
      tick(); tick();
      rst = 1'b1;
      op = 2'b01; a = 32'hFFFF_FFFF; shamt = 5'd3; in_valid = 1'b1;
      tick();
      rst = 1'b0; in_valid = 1'b0;
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_y", y, 32'h0);
      check("abort_in_ready", 32'(in_ready), 32'd1);
      tick();
      check("abort_still_idle", 32'(in_ready), 32'd1);
      issue(2'b01, 32'h0000_00F0, 5'd4);
      await("post_reset", 32'h0000_000F, 5);
      tick(); tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
